// File: rtl/systolic_feeder.sv
// Operand staging and diagonal-skew feeder for an N x N output-stationary systolic array.
// Buffers A and B, then clears the array, streams skewed rows/columns, drains and flags done.
//
// state    | meaning
// S_IDLE   | waiting for start; buffer writes accepted
// S_CLEAR  | one cycle, clr_acc asserted, operands zero
// S_STREAM | 2N-1 cycles, skewed A rows / B columns driven, cnt = t
// S_DRAIN  | N cycles, operands zero while the array finishes accumulating
// S_DONE   | one cycle, done asserted
module systolic_feeder #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [IDX_W-1:0]  wr_row,
  input  logic [IDX_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              clr_acc,
  output logic [DATA_W-1:0] A_out [0:N-1],
  output logic [DATA_W-1:0] B_out [0:N-1],
  output logic              done
);

  localparam int CNT_W = $clog2(2 * N);
  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(2 * N - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] a_mem [0:N-1][0:N-1];
  logic [DATA_W-1:0] b_mem [0:N-1][0:N-1];
  logic [DATA_W-1:0] a_nxt [0:N-1];
  logic [DATA_W-1:0] b_nxt [0:N-1];
  int                diff;

  // Buffers are deliberately outside reset so contents survive an aborted run.
  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE) && (int'(wr_row) < N) && (int'(wr_col) < N)) begin
      if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
      else        a_mem[wr_row][wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLEAR;
          cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        state_nxt = S_STREAM;
        cnt_nxt   = '0;
      end
      S_STREAM: begin
        if (cnt == STREAM_LAST) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Operands are selected for the upcoming step so the registered outputs line up with t.
  always_comb begin
    diff = 0;
    for (int i = 0; i < N; i++) begin
      a_nxt[i] = '0;
      b_nxt[i] = '0;
    end
    if (state_nxt == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        diff = int'(cnt_nxt) - i;
        if ((diff >= 0) && (diff < N)) begin
          a_nxt[i] = a_mem[i][IDX_W'(diff)];
          b_nxt[i] = b_mem[IDX_W'(diff)][i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      clr_acc <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        A_out[i] <= '0;
        B_out[i] <= '0;
      end
    end else begin
      busy    <= (state_nxt != S_IDLE);
      clr_acc <= (state_nxt == S_CLEAR);
      done    <= (state_nxt == S_DONE);
      A_out   <= a_nxt;
      B_out   <= b_nxt;
    end
  end

endmodule
